// File: rtl/fp_add_seq_if.sv
// Handshake and data bundle for the sequential single-precision adder.
// The master launches operands; the slave returns the registered sum.
interface fp_add_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        done;
  logic        busy;

  modport master (output start, output a, output b,
                  input  result, input done, input busy);
  modport slave  (input  start, input a, input b,
                  output result, output done, output busy);
endinterface

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder with truncating rounding and
// denormal flush; one operation in flight, fixed latency from start to done.
//
// state  | meaning
// IDLE   | waiting for start, operands captured on start
// UNPACK | split fields, flush denormals, resolve NaN/Inf/zero operands
// ALIGN  | order by magnitude, shift smaller mantissa right
// ADD    | add or subtract aligned mantissas
// NORM   | single-cycle normalise (carry right-shift or leading-zero left-shift)
// PACK   | assemble result; done pulses in the following cycle
module fp_add_seq (
  input  logic         clk,
  input  logic         rst,
  fp_add_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_ADD    = 3'd3,
    ST_NORM   = 3'd4,
    ST_PACK   = 3'd5
  } state_t;

  state_t r_state, w_next;

  logic [31:0]        r_a, r_b;
  logic               r_sa, r_sb;
  logic [7:0]         r_ea, r_eb;
  logic [23:0]        r_ma, r_mb;
  logic               r_spec;
  logic [31:0]        r_spec_val;
  logic               r_sl, r_sub;
  logic [7:0]         r_el;
  logic [23:0]        r_ml, r_ms;
  logic [24:0]        r_sum;
  logic signed [9:0]  r_exp_n;
  logic [22:0]        r_frac_n;
  logic               r_zero;
  logic [31:0]        r_result;
  logic               r_done;

  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic               w_spec;
  logic [31:0]        w_spec_val;
  logic               w_a_ge;
  logic [7:0]         w_el, w_es, w_diff;
  logic [23:0]        w_ml, w_ms, w_ms_sh;
  logic               w_sl;
  logic [24:0]        w_sum;
  logic [4:0]         w_lzc;
  logic signed [9:0]  w_norm_exp;
  logic [22:0]        w_norm_frac;
  logic [31:0]        w_pack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_next = ST_UNPACK;
      ST_UNPACK: w_next = ST_ALIGN;
      ST_ALIGN:  w_next = ST_ADD;
      ST_ADD:    w_next = ST_NORM;
      ST_NORM:   w_next = ST_PACK;
      ST_PACK:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_a_zero = (r_a[30:23] == 8'h00);
  assign w_b_zero = (r_b[30:23] == 8'h00);
  assign w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);

  // Operands that never need the mantissa datapath resolve here and bypass it.
  always_comb begin
    w_spec     = 1'b1;
    w_spec_val = 32'h0000_0000;
    if (w_a_nan || w_b_nan)           w_spec_val = 32'h7FC0_0000;
    else if (w_a_inf && w_b_inf)      w_spec_val = (r_a[31] != r_b[31]) ? 32'h7FC0_0000 : r_a;
    else if (w_a_inf)                 w_spec_val = r_a;
    else if (w_b_inf)                 w_spec_val = r_b;
    else if (w_a_zero && w_b_zero)    w_spec_val = {r_a[31] & r_b[31], 31'd0};
    else if (w_a_zero)                w_spec_val = r_b;
    else if (w_b_zero)                w_spec_val = r_a;
    else                              w_spec     = 1'b0;
  end

  assign w_a_ge  = {r_ea, r_ma} >= {r_eb, r_mb};
  assign w_sl    = w_a_ge ? r_sa : r_sb;
  assign w_el    = w_a_ge ? r_ea : r_eb;
  assign w_es    = w_a_ge ? r_eb : r_ea;
  assign w_ml    = w_a_ge ? r_ma : r_mb;
  assign w_ms    = w_a_ge ? r_mb : r_ma;
  assign w_diff  = w_el - w_es;
  assign w_ms_sh = (w_diff > 8'd25) ? 24'd0 : (w_ms >> w_diff);

  assign w_sum = r_sub ? ({1'b0, r_ml} - {1'b0, r_ms}) : ({1'b0, r_ml} + {1'b0, r_ms});

  // Highest set bit wins because the loop runs upward.
  always_comb begin
    w_lzc = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (r_sum[i]) w_lzc = 5'(23 - i);
    end
  end

  always_comb begin
    if (r_sum[24]) begin
      w_norm_exp  = $signed({2'b00, r_el}) + 10'sd1;
      w_norm_frac = r_sum[23:1];
    end else begin
      w_norm_exp  = $signed({2'b00, r_el}) - $signed({5'b00000, w_lzc});
      w_norm_frac = r_sum[22:0] << w_lzc;
    end
  end

  always_comb begin
    if (r_spec)                      w_pack = r_spec_val;
    else if (r_zero)                 w_pack = 32'h0000_0000;
    else if (r_exp_n >= 10'sd255)    w_pack = {r_sl, 8'hFF, 23'd0};
    else if (r_exp_n <= 10'sd0)      w_pack = {r_sl, 31'd0};
    else                             w_pack = {r_sl, r_exp_n[7:0], r_frac_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_ea       <= '0;
      r_eb       <= '0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_spec     <= 1'b0;
      r_spec_val <= '0;
      r_sl       <= 1'b0;
      r_sub      <= 1'b0;
      r_el       <= '0;
      r_ml       <= '0;
      r_ms       <= '0;
      r_sum      <= '0;
      r_exp_n    <= '0;
      r_frac_n   <= '0;
      r_zero     <= 1'b0;
      r_result   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_PACK);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a <= bus.a;
            r_b <= bus.b;
          end
        end
        ST_UNPACK: begin
          r_sa       <= r_a[31];
          r_sb       <= r_b[31];
          r_ea       <= r_a[30:23];
          r_eb       <= r_b[30:23];
          r_ma       <= w_a_zero ? 24'd0 : {1'b1, r_a[22:0]};
          r_mb       <= w_b_zero ? 24'd0 : {1'b1, r_b[22:0]};
          r_spec     <= w_spec;
          r_spec_val <= w_spec_val;
        end
        ST_ALIGN: begin
          r_sl  <= w_sl;
          r_sub <= r_sa ^ r_sb;
          r_el  <= w_el;
          r_ml  <= w_ml;
          r_ms  <= w_ms_sh;
        end
        ST_ADD: begin
          r_sum <= w_sum;
        end
        ST_NORM: begin
          r_exp_n  <= w_norm_exp;
          r_frac_n <= w_norm_frac;
          r_zero   <= (r_sum == 25'd0);
        end
        ST_PACK: begin
          r_result <= w_pack;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;
  assign bus.busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed-vector bench for fp_add_seq: latency, arithmetic corner cases,
// start-while-busy rejection and asynchronous reset mid-operation.
module tb_fp_add_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fp_add_seq_if bus ();

  fp_add_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation, expect done five edges after the start edge.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = va;
    bus.b     = vb;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd5);
    chk({tag, "_result"}, bus.result, exp);
    chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    int lat;
    logic [31:0] res;
    checks    = 0;
    failures  = 0;
    bus.start = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    rst       = 1'b1;
    #12;
    chk("reset_result", bus.result, 32'h0000_0000);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("one_plus_two",  32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    run_op("cancel",        32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    run_op("truncate",      32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    run_op("carry_norm",    32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);
    run_op("lzc_norm",      32'h4040_0000, 32'hC020_0000, 32'h3F00_0000);
    run_op("overflow",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    run_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run_op("nan_in",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    run_op("inf_plus_one",  32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000);
    run_op("neg_inf_pair",  32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000);
    run_op("denorm_flush",  32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000);
    run_op("neg_zeros",     32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_op("zero_pass",     32'h0000_0000, 32'h40A0_0000, 32'h40A0_0000);
    run_op("mixed_zeros",   32'h8000_0000, 32'h0000_0000, 32'h0000_0000);
    run_op("underflow",     32'h0080_0000, 32'h80C0_0000, 32'h8000_0000);

    // Second start while in ALIGN must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h3F80_0000;
    bus.b     = 32'h4000_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h4120_0000;
    bus.b     = 32'h4120_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    lat    = 0;
    res    = 32'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        pulses++;
        res = bus.result;
        lat = i + 3;
      end
    end
    chk("busy_start_pulses", pulses, 32'd1);
    chk("busy_start_latency", lat, 32'd5);
    chk("busy_start_result", res, 32'h4040_0000);
    chk("busy_start_idle", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset during ADD.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h3FC0_0000;
    bus.b     = 32'h4020_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
    chk("rst_mid_result", bus.result, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("rst_no_done", pulses, 32'd0);
    chk("rst_idle", {31'd0, bus.busy}, 32'd0);

    run_op("after_reset", 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
